pc_sequencer: RTL

Parametrised program-counter unit for the single-cycle core. It holds the architectural PC, computes the sequential successor, and selects the next PC from branch, jump and return sources. It also keeps a small return-address stack (RAS) for call/return. It sits at the front of the fetch path and drives the instruction-memory address and the PC+INC value used by writeback.

---
 rtl/pc_pkg.sv | 10 +
 rtl/ras_stack.sv | 54 +++++
 rtl/pc_sequencer.sv | 64 ++++++
 3 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared types and sizing helpers for the program-counter unit.
package pc_pkg;
  typedef enum logic [2:0] {SEL_HOLD, SEL_RET, SEL_JUMP, SEL_BRANCH, SEL_SEQ} next_sel_e;
  function automatic int ptr_width(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction
  function automatic int align_bits(input int inc);
    return $clog2(inc);
  endfunction
endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack with saturating count and overflow/underflow pulses.
module ras_stack
  import pc_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);
  localparam int PW = ptr_width(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PW-1:0] ptr, ptr_inc, ptr_dec, ptr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic swap, pop_ok;
  assign top = mem[ptr];
  // swap: simultaneous pop+push on a non-empty stack rewrites the top in place
  always_comb begin
    swap    = push & pop & ~empty;
    pop_ok  = pop & ~push & ~empty;
    ptr_inc = (ptr == PW'(RAS_DEPTH - 1)) ? '0 : ptr + 1'b1;
    ptr_dec = (ptr == '0) ? PW'(RAS_DEPTH - 1) : ptr - 1'b1;
    ptr_n   = swap ? ptr : push ? ptr_inc : pop_ok ? ptr_dec : ptr;
    cnt_n   = swap ? cnt : push ? (full ? cnt : cnt + 1'b1) : pop_ok ? cnt - 1'b1 : cnt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      cnt       <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      ptr       <= ptr_n;
      cnt       <= cnt_n;
      empty     <= cnt_n == '0;
      full      <= cnt_n == CW'(RAS_DEPTH);
      overflow  <= push & ~pop & full;
      underflow <= pop & empty;
    end
  end
  always_ff @(posedge clk)
    if (push) mem[ptr_n] <= push_data;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: architectural PC register with prioritised next-PC selection,
// target alignment and a return-address stack for call/return.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               INC       = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int               RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_offset,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] pc_output,
  output logic [WIDTH-1:0] pc_plus,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_overflow,
  output logic             ras_underflow,
  output logic             misalign
);
  localparam int               ALIGN_BITS = align_bits(INC);
  localparam logic [WIDTH-1:0] LOW        = WIDTH'(INC - 1);
  next_sel_e        sel;
  logic [WIDTH-1:0] ras_top, target, pc_n;
  logic             chk, mis_n;
  assign pc_plus = pc_output + WIDTH'(INC);
  always_comb begin
    sel    = stall ? SEL_HOLD : ret ? SEL_RET : jump ? SEL_JUMP : branch_taken ? SEL_BRANCH : SEL_SEQ;
    target = (sel == SEL_RET) ? (ras_empty ? pc_plus : ras_top) :
             (sel == SEL_JUMP) ? jump_target : pc_output + branch_offset;
    chk    = (sel == SEL_RET && !ras_empty) || sel == SEL_JUMP || sel == SEL_BRANCH;
    mis_n  = chk && ALIGN_BITS != 0 && |(target & LOW);
    pc_n   = (sel == SEL_HOLD) ? pc_output : (sel == SEL_SEQ) ? pc_plus :
             chk ? (target & ~LOW) : target;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_output <= RESET_VEC;
      misalign  <= 1'b0;
    end else begin
      pc_output <= pc_n;
      misalign  <= mis_n;
    end
  end
  ras_stack #(.WIDTH(WIDTH), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .rst_n     (reset),
    .push      (call & ~stall),
    .pop       (ret & ~stall),
    .push_data (pc_plus),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .overflow  (ras_overflow),
    .underflow (ras_underflow)
  );
endmodule
